// File: rtl/sequenceur_lancer_if.sv
// -----------------------------------------------------------------------------
// sequenceur_lancer_if
// Groups the button inputs and the command/display outputs of the dice-roller
// front-end controller.
//   suivant_n, lancer_n : raw active-low push buttons (0 = pressed)
//   suivant             : one-cycle strobe, advance die type
//   roule               : roll unit keeps randomising while high
//   fige                : one-cycle strobe, roll unit latches its result
//   affiche_anim        : 1 = displays show anim_seg, 0 = show result
//   anim_seg            : rotating segment pattern, active-low, bit0=a..bit6=g
//   occupe              : high while the rolling animation runs
// Modports: master = button side / observer, slave = controller.
// -----------------------------------------------------------------------------
interface sequenceur_lancer_if;
  logic       suivant_n;
  logic       lancer_n;
  logic       suivant;
  logic       roule;
  logic       fige;
  logic       affiche_anim;
  logic [6:0] anim_seg;
  logic       occupe;

  modport master (
    output suivant_n,
    output lancer_n,
    input  suivant,
    input  roule,
    input  fige,
    input  affiche_anim,
    input  anim_seg,
    input  occupe
  );

  modport slave (
    input  suivant_n,
    input  lancer_n,
    output suivant,
    output roule,
    output fige,
    output affiche_anim,
    output anim_seg,
    output occupe
  );
endinterface

// File: rtl/sequenceur_lancer.sv
// -----------------------------------------------------------------------------
// sequenceur_lancer
// Front-end controller of the dice roller. Each active-low button goes through
// a 2-flop synchroniser and a debouncer; a debounced press (1->0) becomes a
// single-cycle command. A three-state FSM (REPOS / ANIM / RESULTAT) times the
// rolling animation and emits the freeze strobe at its end.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : sequenceur_lancer_if.slave (buttons in, commands/display out)
// Parameters:
//   DEBOUNCE_CYC : stable cycles needed to accept a button level change
//   ANIM_CYC     : length of the rolling phase in cycles
//   ANIM_STEP    : cycles per animation segment (ANIM_STEP <= ANIM_CYC)
// -----------------------------------------------------------------------------
module sequenceur_lancer #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int ANIM_CYC     = 25000000,
  parameter int ANIM_STEP    = 2500000
) (
  input logic                clk,
  input logic                reset_n,
  sequenceur_lancer_if.slave bus
);

  // Counter widths, never below one bit.
  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int AN_W = (ANIM_CYC > 1) ? $clog2(ANIM_CYC) : 1;
  localparam int ST_W = (ANIM_STEP > 1) ? $clog2(ANIM_STEP) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [AN_W-1:0] AN_LAST = AN_W'(ANIM_CYC - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(ANIM_STEP - 1);

  localparam int BTN_SUIV = 0;
  localparam int BTN_LANC = 1;

  typedef enum logic [1:0] {
    REPOS    = 2'd0,
    ANIM     = 2'd1,
    RESULTAT = 2'd2
  } state_t;

  // Active-low one-hot-ish rotation over segments a..f; g is never lit.
  function automatic logic [6:0] seg_pattern(input logic [2:0] idx);
    logic [6:0] pat;
    case (idx)
      3'd0:    pat = 7'h7E;
      3'd1:    pat = 7'h7D;
      3'd2:    pat = 7'h7B;
      3'd3:    pat = 7'h77;
      3'd4:    pat = 7'h6F;
      3'd5:    pat = 7'h5F;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic [1:0] raw_s;
  logic [1:0] press_s;
  logic [1:0] fill_r;

  assign raw_s = {bus.lancer_n, bus.suivant_n};

  // Tracks when the synchroniser holds genuine samples (two cycles after reset),
  // so the reset value of the sync flops is never mistaken for a released button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_r <= 2'b00;
    end else begin
      fill_r <= {fill_r[0], 1'b1};
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic            sync1_r;
    logic            sync2_r;
    logic            deb_r;
    logic            armed_r;
    logic [DB_W-1:0] cnt_r;

    // Two-flop synchroniser for the raw button level.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_r <= 1'b1;
        sync2_r <= 1'b1;
      end else begin
        sync1_r <= raw_s[g];
        sync2_r <= sync1_r;
      end
    end

    // Debouncer: the new level is accepted after DEBOUNCE_CYC consecutive
    // differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        deb_r <= 1'b1;
        cnt_r <= {DB_W{1'b0}};
      end else if (sync2_r == deb_r) begin
        cnt_r <= {DB_W{1'b0}};
      end else if (cnt_r == DB_LAST) begin
        deb_r <= sync2_r;
        cnt_r <= {DB_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + DB_W'(1);
      end
    end

    // A button only becomes live once it has been seen released after reset,
    // so a button held through reset release never produces a press.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        armed_r <= 1'b0;
      end else if (fill_r[1] && sync2_r && deb_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end

    // Press is flagged in the cycle the debouncer accepts the 1->0 change, so
    // the FSM reacts on the same edge that lowers the debounced level.
    assign press_s[g] = armed_r & deb_r & ~sync2_r & (cnt_r == DB_LAST);
  end

  logic lancer_ev_s;
  logic suivant_ev_s;

  assign lancer_ev_s  = press_s[BTN_LANC];
  assign suivant_ev_s = press_s[BTN_SUIV];

  state_t          state_r;
  state_t          state_nx_s;
  logic [AN_W-1:0] anim_cnt_r;
  logic [AN_W-1:0] anim_cnt_nx_s;
  logic [ST_W-1:0] step_cnt_r;
  logic [ST_W-1:0] step_cnt_nx_s;
  logic [2:0]      idx_r;
  logic [2:0]      idx_nx_s;
  logic            suivant_nx_s;
  logic            fige_nx_s;
  logic            roule_nx_s;
  logic            affiche_nx_s;
  logic            occupe_nx_s;
  logic [6:0]      anim_seg_nx_s;

  logic            suivant_r;
  logic            fige_r;
  logic            roule_r;
  logic            affiche_r;
  logic            occupe_r;
  logic [6:0]      anim_seg_r;

  // Next-state and command logic; counters default to zero so entering ANIM
  // from any state reloads them.
  always_comb begin
    state_nx_s    = state_r;
    anim_cnt_nx_s = {AN_W{1'b0}};
    step_cnt_nx_s = {ST_W{1'b0}};
    idx_nx_s      = 3'd0;
    suivant_nx_s  = 1'b0;
    fige_nx_s     = 1'b0;
    case (state_r)
      REPOS: begin
        if (lancer_ev_s) begin
          state_nx_s = ANIM;
        end else if (suivant_ev_s) begin
          suivant_nx_s = 1'b1;
          state_nx_s   = REPOS;
        end else begin
          state_nx_s = REPOS;
        end
      end
      ANIM: begin
        // Button events are simply ignored here, never queued.
        if (anim_cnt_r == AN_LAST) begin
          state_nx_s = RESULTAT;
          fige_nx_s  = 1'b1;
        end else begin
          state_nx_s    = ANIM;
          anim_cnt_nx_s = anim_cnt_r + AN_W'(1);
          if (step_cnt_r == ST_LAST) begin
            step_cnt_nx_s = {ST_W{1'b0}};
            if (idx_r == 3'd5) begin
              idx_nx_s = 3'd0;
            end else begin
              idx_nx_s = idx_r + 3'd1;
            end
          end else begin
            step_cnt_nx_s = step_cnt_r + ST_W'(1);
            idx_nx_s      = idx_r;
          end
        end
      end
      RESULTAT: begin
        if (lancer_ev_s) begin
          state_nx_s = ANIM;
        end else if (suivant_ev_s) begin
          suivant_nx_s = 1'b1;
          state_nx_s   = REPOS;
        end else begin
          state_nx_s = RESULTAT;
        end
      end
      default: begin
        state_nx_s = REPOS;
      end
    endcase
  end

  // Level outputs follow the state being entered so they register together
  // with the state; this makes roule fall on the same edge fige rises.
  always_comb begin
    roule_nx_s    = 1'b0;
    affiche_nx_s  = 1'b0;
    occupe_nx_s   = 1'b0;
    anim_seg_nx_s = 7'h7F;
    if (state_nx_s == ANIM) begin
      roule_nx_s    = 1'b1;
      affiche_nx_s  = 1'b1;
      occupe_nx_s   = 1'b1;
      anim_seg_nx_s = seg_pattern(idx_nx_s);
    end else begin
      roule_nx_s    = 1'b0;
      affiche_nx_s  = 1'b0;
      occupe_nx_s   = 1'b0;
      anim_seg_nx_s = 7'h7F;
    end
  end

  // State, animation counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= REPOS;
      anim_cnt_r <= {AN_W{1'b0}};
      step_cnt_r <= {ST_W{1'b0}};
      idx_r      <= 3'd0;
      suivant_r  <= 1'b0;
      fige_r     <= 1'b0;
      roule_r    <= 1'b0;
      affiche_r  <= 1'b0;
      occupe_r   <= 1'b0;
      anim_seg_r <= 7'h7F;
    end else begin
      state_r    <= state_nx_s;
      anim_cnt_r <= anim_cnt_nx_s;
      step_cnt_r <= step_cnt_nx_s;
      idx_r      <= idx_nx_s;
      suivant_r  <= suivant_nx_s;
      fige_r     <= fige_nx_s;
      roule_r    <= roule_nx_s;
      affiche_r  <= affiche_nx_s;
      occupe_r   <= occupe_nx_s;
      anim_seg_r <= anim_seg_nx_s;
    end
  end

  assign bus.suivant      = suivant_r;
  assign bus.fige         = fige_r;
  assign bus.roule        = roule_r;
  assign bus.affiche_anim = affiche_r;
  assign bus.occupe       = occupe_r;
  assign bus.anim_seg     = anim_seg_r;

endmodule

// File: tb/tb_sequenceur_lancer.sv
// -----------------------------------------------------------------------------
// tb_sequenceur_lancer
// Bench for sequenceur_lancer with DEBOUNCE_CYC=4, ANIM_CYC=12, ANIM_STEP=2.
// Button scenarios come from a table; expected pulse counts are queued when a
// scenario starts and compared once its window has elapsed. Cycle-exact
// sequences (roll trace, reset during a roll) queue per-cycle expectations.
// -----------------------------------------------------------------------------
module tb_sequenceur_lancer;

  localparam int P_DEB  = 4;
  localparam int P_ANIM = 12;
  localparam int P_STEP = 2;
  localparam int LAT    = 2 + P_DEB;

  logic clk;
  logic reset_n;

  sequenceur_lancer_if bus_if ();

  sequenceur_lancer #(
    .DEBOUNCE_CYC (P_DEB),
    .ANIM_CYC     (P_ANIM),
    .ANIM_STEP    (P_STEP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Button scenario: mask bit1 = lancer, bit0 = suivant.
  typedef struct {
    string    name;
    bit [1:0] m1;
    int       h1;
    bit [1:0] m2;
    int       off2;
    int       h2;
    int       len;
    int       e_suiv;
    int       e_roule;
    int       e_fige;
  } vec_t;

  typedef struct {
    string name;
    int    e_suiv;
    int    e_roule;
    int    e_fige;
  } sb_t;

  typedef struct {
    int         due;
    int         k;
    logic       suiv;
    logic       roule;
    logic       fige;
    logic       aff;
    logic       occ;
    logic [6:0] seg;
  } cyc_exp_t;

  vec_t       tbl [9];
  sb_t        sb_q [$];
  cyc_exp_t   cyc_q [$];
  logic [6:0] seg_tab [6] = '{7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F};

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   c_suiv, r_suiv, c_roule, c_fige, r_fige, misalign;
  logic prev_suiv = 1'b0;
  logic prev_roule = 1'b0;
  logic prev_fige = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    c_suiv = 0; r_suiv = 0; c_roule = 0; c_fige = 0; r_fige = 0; misalign = 0;
  endtask

  // One clock: sample #1 after the edge, accumulate pulse statistics and
  // compare any per-cycle expectation due now.
  task automatic tick();
    cyc_exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (bus_if.suivant === 1'b1) begin
      c_suiv++;
      if (prev_suiv !== 1'b1) r_suiv++;
    end
    if (bus_if.roule === 1'b1) c_roule++;
    if (bus_if.fige === 1'b1) begin
      c_fige++;
      if (prev_fige !== 1'b1) r_fige++;
      if (!(bus_if.roule === 1'b0 && prev_roule === 1'b1)) misalign++;
    end
    prev_suiv  = bus_if.suivant;
    prev_roule = bus_if.roule;
    prev_fige  = bus_if.fige;
    while (cyc_q.size() > 0 && cyc_q[0].due == cyc) begin
      e = cyc_q.pop_front();
      chk($sformatf("trace k%0d suivant", e.k), {31'd0, bus_if.suivant}, {31'd0, e.suiv});
      chk($sformatf("trace k%0d roule", e.k), {31'd0, bus_if.roule}, {31'd0, e.roule});
      chk($sformatf("trace k%0d fige", e.k), {31'd0, bus_if.fige}, {31'd0, e.fige});
      chk($sformatf("trace k%0d affiche", e.k), {31'd0, bus_if.affiche_anim}, {31'd0, e.aff});
      chk($sformatf("trace k%0d occupe", e.k), {31'd0, bus_if.occupe}, {31'd0, e.occ});
      chk($sformatf("trace k%0d seg", e.k), {25'd0, bus_if.anim_seg}, {25'd0, e.seg});
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " suivant"}, {31'd0, bus_if.suivant}, 32'd0);
    chk({tag, " roule"}, {31'd0, bus_if.roule}, 32'd0);
    chk({tag, " fige"}, {31'd0, bus_if.fige}, 32'd0);
    chk({tag, " affiche"}, {31'd0, bus_if.affiche_anim}, 32'd0);
    chk({tag, " occupe"}, {31'd0, bus_if.occupe}, 32'd0);
    chk({tag, " seg"}, {25'd0, bus_if.anim_seg}, 32'h7F);
  endtask

  // Plays one table scenario, then pops its scoreboard entry and compares.
  task automatic run_vec(input vec_t v);
    sb_t s;
    bit  lo_l, lo_s;
    clr();
    sb_q.push_back('{v.name, v.e_suiv, v.e_roule, v.e_fige});
    for (int t = 0; t < v.len; t++) begin
      lo_l = (v.m1[1] && t < v.h1) || (v.m2[1] && t >= v.off2 && t < v.off2 + v.h2);
      lo_s = (v.m1[0] && t < v.h1) || (v.m2[0] && t >= v.off2 && t < v.off2 + v.h2);
      bus_if.lancer_n  = ~lo_l;
      bus_if.suivant_n = ~lo_s;
      tick();
    end
    s = sb_q.pop_front();
    chk({s.name, " suivant cycles"}, c_suiv, s.e_suiv);
    chk({s.name, " suivant pulses"}, r_suiv, s.e_suiv);
    chk({s.name, " roule cycles"}, c_roule, s.e_roule);
    chk({s.name, " fige cycles"}, c_fige, s.e_fige);
    chk({s.name, " fige pulses"}, r_fige, s.e_fige);
    chk({s.name, " fige vs roule fall"}, misalign, 0);
    chk({s.name, " end affiche"}, {31'd0, bus_if.affiche_anim}, 32'd0);
    chk({s.name, " end occupe"}, {31'd0, bus_if.occupe}, 32'd0);
  endtask

  initial begin
    int  c0;
    bit  r;
    tbl[0] = '{"glitch3",      2'b10, 3, 2'b00, 0,  0, 16, 0, 0,      0};
    tbl[1] = '{"select1",      2'b01, 6, 2'b00, 0,  0, 14, 1, 0,      0};
    tbl[2] = '{"select2",      2'b01, 6, 2'b00, 0,  0, 14, 1, 0,      0};
    tbl[3] = '{"select3",      2'b01, 6, 2'b00, 0,  0, 14, 1, 0,      0};
    tbl[4] = '{"both_repos",   2'b11, 6, 2'b00, 0,  0, 26, 0, P_ANIM, 1};
    tbl[5] = '{"both_result",  2'b11, 6, 2'b00, 0,  0, 26, 0, P_ANIM, 1};
    tbl[6] = '{"result_suiv",  2'b01, 6, 2'b00, 0,  0, 14, 1, 0,      0};
    tbl[7] = '{"lancer_after", 2'b10, 6, 2'b00, 0,  0, 26, 0, P_ANIM, 1};
    tbl[8] = '{"lockout",      2'b10, 4, 2'b11, 10, 6, 32, 0, P_ANIM, 1};

    // Reset state.
    reset_n          = 1'b0;
    bus_if.lancer_n  = 1'b1;
    bus_if.suivant_n = 1'b1;
    clr();
    repeat (3) tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Roll trace from RESULTAT: lancer held 10 cycles, cycle-exact outputs.
    c0 = cyc;
    for (int k = 1; k <= 22; k++) begin
      r = (k >= LAT) && (k < LAT + P_ANIM);
      cyc_q.push_back('{c0 + k, k, 1'b0, r, (k == LAT + P_ANIM), r, r,
                        r ? seg_tab[(k - LAT) / P_STEP] : 7'h7F});
    end
    for (int t = 0; t < 22; t++) begin
      bus_if.lancer_n = (t < 10) ? 1'b0 : 1'b1;
      tick();
    end
    chk("trace drained", cyc_q.size(), 0);

    // Reset in ANIM cycle 5 with lancer held low across reset release.
    clr();
    for (int t = 0; t < LAT + 5; t++) begin
      bus_if.lancer_n = (t < 4) ? 1'b0 : 1'b1;
      tick();
    end
    chk("pre-reset roule", {31'd0, bus_if.roule}, 32'd1);
    chk("pre-reset seg", {25'd0, bus_if.anim_seg}, 32'h7B);
    #2;
    reset_n         = 1'b0;
    bus_if.lancer_n = 1'b0;
    #1;
    check_reset_values("async reset");
    clr();
    repeat (3) tick();
    chk("in reset fige", c_fige, 0);
    chk("in reset roule", c_roule, 0);
    reset_n = 1'b1;
    clr();
    repeat (15) tick();
    chk("held lancer roule", c_roule, 0);
    chk("held lancer fige", c_fige, 0);
    chk("held lancer suivant", c_suiv, 0);
    bus_if.lancer_n = 1'b1;
    repeat (10) tick();
    run_vec(tbl[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sequenceur_lancer.md
Name: sequenceur_lancer

Overview:
Front-end controller for the dice-roller datapath. It synchronises and debounces the two active-low push buttons, converts presses into single-cycle commands, and sequences each roll through a timed "rolling" animation phase before freezing the result. Its outputs drive the die-type selector (advance strobe), the roll unit (run/freeze controls) and the result display mux (animation vs result).

Parameters:
DEBOUNCE_CYC, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz)
ANIM_CYC, 25000000, duration of the rolling phase in clk cycles (0.5 s)
ANIM_STEP, 2500000, cycles per animation segment step; ANIM_STEP <= ANIM_CYC

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
suivant_n  in  1  raw "next die type" button, 0 when pressed
lancer_n  in  1  raw "roll" button, 0 when pressed
suivant  out  1  one-cycle strobe: advance die type
roule  out  1  high while roll unit must keep randomising
fige  out  1  one-cycle strobe: roll unit latches current value as result
affiche_anim  out  1  1 = result displays show anim_seg, 0 = show result
anim_seg  out  7  rotating segment pattern, active-low, bit0=a .. bit6=g
occupe  out  1  high in ANIM state

Behaviour:
- One clock; reset is asynchronous and active-low. All flops clear asynchronously on reset_n=0.
- Reset values: suivant=0, roule=0, fige=0, affiche_anim=0, occupe=0, anim_seg=7'h7F, state=REPOS. Sync flops and debounced levels = 1 (released). All counters = 0.
- Input path per button: 2-flop synchroniser, then debouncer.
- Debouncer: counter clears while sync==deb. It increments while sync!=deb. When sync!=deb and the counter has reached DEBOUNCE_CYC-1, deb<=sync and the counter clears. Any glitch shorter than DEBOUNCE_CYC cycles is rejected.
- Press event = deb transition 1->0. Releases generate no event.
- Total raw-edge-to-event latency is 2 + DEBOUNCE_CYC cycles.
- A button held through reset release produces no event. It must first be released, then pressed again.
- Command strobes (suivant, fige) are registered and high exactly one cycle.
- FSM states: REPOS, ANIM, RESULTAT.
- REPOS:
  - suivant press -> suivant=1 on the next cycle; stay in REPOS.
  - lancer press -> ANIM.
- ANIM, on entry:
  - load anim counter=0, step counter=0, segment index=0.
  - roule=1, affiche_anim=1, occupe=1.
- ANIM, while active:
  - anim_seg = all ones except bit[idx]=0.
  - idx runs 0..5 (segments a..f). It advances when the step counter reaches ANIM_STEP-1, then the step counter clears; idx wraps 5->0. Segment g is never lit.
  - All suivant and lancer press events are discarded, not queued.
- ANIM exit: when the anim counter reaches ANIM_CYC-1, go to RESULTAT with fige=1 for one cycle. roule falls in the same cycle fige rises.
- RESULTAT: roule=0, affiche_anim=0, occupe=0, anim_seg=7'h7F.
  - lancer press -> ANIM (re-roll; counters reloaded).
  - suivant press -> suivant strobe, then REPOS. Outputs stay the same as in RESULTAT.
- Simultaneous suivant and lancer events in the same cycle (REPOS or RESULTAT): lancer wins, suivant is discarded.
- Reset asserted mid-ANIM: immediate return to reset values. No fige is emitted.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. No overflow is possible because each counter is cleared at its terminal value.

Test Plan:
- Bench parameters for all tests: DEBOUNCE_CYC=4, ANIM_CYC=12, ANIM_STEP=2.
- Debounce: lancer_n low for 3 cycles then high -> no event. Low for 10 cycles -> ANIM entered exactly 6 cycles after the falling edge; no event on release.
- Select: suivant_n pressed 3 times in REPOS with clean presses -> exactly 3 single-cycle suivant pulses; roule stays 0.
- Roll sequence: lancer press -> roule=1 for 12 cycles. anim_seg steps 7'h7E,7'h7D,7'h7B,7'h77,7'h6F,7'h5F, 2 cycles each. Then one fige pulse in the cycle roule falls, then affiche_anim=0.
- Lockout and priority: during ANIM, press both buttons -> no suivant pulse and no extension. In RESULTAT, press both in the same cycle -> ANIM restarts and no suivant pulse.
- Reset: assert reset_n=0 at ANIM cycle 5 -> all outputs to reset values asynchronously, no fige. Hold lancer_n=0 across reset release -> no ANIM until release plus a new press.
- RESULTAT exit: suivant press in RESULTAT -> one suivant pulse, state REPOS. A following lancer press starts a new ANIM.
